mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing one single-ported memory between the pipeline's instruction-fetch stage and its data-memory stage. It sequences every access through a registered request/ready handshake on the memory side. It returns combinational acknowledge and stall signals so the hazard logic can freeze the requesting stage until its access completes. It sits between the core pipeline and the unified memory (later the bus-interface bridge).

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; DATA_W/8 byte strobes
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (range 1-15)

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data, valid when if_ack
- if_ack  out  1  fetch complete (combinational)
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data, valid when dm_ack
- dm_ack  out  1  data access complete (combinational)
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  dm_req & ~dm_ack
- mem_valid  out  1  memory request valid (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  ADDR_W  address (registered)
- mem_wdata  out  DATA_W  write data (registered)
- mem_wstrb  out  DATA_W/8  byte enables (registered; all-zero for loads and fetches)
- mem_ready  in  1  memory accepts/completes the current request
- mem_rdata  in  DATA_W  read data, valid with mem_ready

## Operation
- FSM states: IDLE, GNT_IF, GNT_DM.
- IDLE: if any request is present, grant at the next edge:
  - dm_req wins, unless if_req is high and starve_cnt == STARVE_LIMIT; then fetch wins.
  - With a single request, that requester wins.
  - On grant, latch the address, write data, write enable and strobes into the mem_* registers, set mem_valid = 1, and enter GNT_IF or GNT_DM.
- GNT_x: mem_* outputs are held stable.
  - At the edge where mem_valid & mem_ready: clear mem_valid and return to IDLE.
  - No re-arbitration happens at the completion edge. The requester's req is still the old one on that edge.
- Acknowledge: x_ack = (state == GNT_x) & mem_valid & mem_ready.
- Read data: x_rdata = mem_rdata passthrough. The non-granted rdata is also mem_rdata; consumers qualify it with ack.
- starve_cnt is 4 bits:
  - +1 on each data grant while if_req = 1, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant or in any cycle with if_req = 0.
- Fetches are always reads: mem_we = 0 and mem_wstrb = 0.
- A requester dropping req while granted is a protocol violation. The transaction still completes and ack is still generated.
- Reset values: state IDLE, mem_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, starve_cnt 0. While reset is high, if_ack and dm_ack are 0 and stall_x follows x_req.
- Reset mid-transaction aborts immediately (asynchronous). No ack is issued. The memory must tolerate a dropped mem_valid.

## Timing
- Minimum latency: req high in cycle 0 (state IDLE) gives mem_valid in cycle 1. If mem_ready = 1 in cycle 1, ack is high in cycle 1.
- Each memory wait state adds one cycle. mem_* registers do not change while mem_valid & ~mem_ready.
- Peak throughput is one access per 2 cycles (grant cycle + access cycle).
- Simultaneous requests in IDLE with mem_ready tied high: data acks in cycle 1, fetch is granted at the edge ending cycle 2 and acks in cycle 3.
- stall_x and ack are combinational from state and mem_ready. There is no combinational path from req to mem_*.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE = 2'b00, GNT_IF = 2'b01, GNT_DM = 2'b10)
  - the default widths
- No sub-module is required.
- Optional sub-module starve_counter for the saturating counter, to allow unit testing.

## Test plan
- Lone fetch, mem_ready = 1, if_addr = 0x0000_0000, mem_rdata = 0x0050_0093:
  - mem_valid and mem_addr = 0x0 in cycle 1.
  - if_ack = 1 and if_rdata = 0x0050_0093 in cycle 1.
  - stall_if high in cycle 0 only.
- Simultaneous if_addr = 0x10 and dm load at 0x100, mem_ready = 1:
  - mem_addr = 0x100 and dm_ack in cycle 1.
  - mem_addr = 0x10 and if_ack in cycle 3.
  - stall_if high in cycles 0-2.
- Wait states, mem_ready low for 3 cycles then high:
  - mem_addr, mem_wdata and mem_wstrb stay constant.
  - ack appears only in the ready cycle.
  - stall stays high until then.
- Store: dm_we = 1, dm_addr = 0x200, dm_wdata = 0xDEAD_BEEF, dm_wstrb = 4'b0011:
  - mem_we = 1, mem_wstrb = 4'b0011, mem_wdata = 0xDEAD_BEEF.
  - The following fetch drives mem_we = 0, mem_wstrb = 0.
- Starvation, STARVE_LIMIT = 4, with dm_req and if_req held continuously:
  - grants go data ×4, then fetch, then data.
  - starve_cnt reads 0 after the fetch grant.
- Reset asserted mid-cycle during GNT_DM with mem_valid = 1:
  - mem_valid drops to 0 before the next edge and no dm_ack is issued.
  - After reset release, a pending dm_req is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths and FSM encoding for the fetch/data memory arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W     = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'b00;
    localparam arb_state_t ST_GNT_IF = 2'b01;
    localparam arb_state_t ST_GNT_DM = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and memory-side signals of the arbiter
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ack;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_wstrb;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_ack;

    logic                  stall_if;
    logic                  stall_mem;

    logic                  mem_valid;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter view: drives acks, stalls and the registered memory request.
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  mem_ready, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    // Environment view: pipeline requesters plus the memory.
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output mem_ready, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of data grants taken while fetch waits
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req_i,
    input  logic                    if_grant_i,
    input  logic                    dm_grant_i,
    output logic [STARVE_CNT_W-1:0] cnt_o
);
    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_grant_i) begin
            cnt_d = '0;
        end else if (dm_grant_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between instruction fetch and data access
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t              state_q, state_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]       mem_wstrb_q, mem_wstrb_d;

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    starved;
    logic                    grant_if;
    logic                    grant_dm;
    logic                    done;

    // Data normally wins; fetch takes over once data has starved it for STARVE_LIMIT grants.
    assign starved  = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));
    assign grant_dm = (state_q == ST_IDLE) && bus.dm_req && !(bus.if_req && starved);
    assign grant_if = (state_q == ST_IDLE) && bus.if_req && !grant_dm;
    assign done     = mem_valid_q && bus.mem_ready;

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_dm) begin
                    state_d     = ST_GNT_DM;
                    mem_valid_d = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_wstrb_d = bus.dm_we ? bus.dm_wstrb : '0;
                end else if (grant_if) begin
                    state_d     = ST_GNT_IF;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wstrb_d = '0;
                end
            end
            ST_GNT_IF, ST_GNT_DM: begin
                if (done) begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    mem_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (bus.if_req),
        .if_grant_i (grant_if),
        .dm_grant_i (grant_dm),
        .cnt_o      (starve_cnt)
    );

    assign bus.if_ack    = (state_q == ST_GNT_IF) && done;
    assign bus.dm_ack    = (state_q == ST_GNT_DM) && done;
    assign bus.stall_if  = bus.if_req && !bus.if_ack;
    assign bus.stall_mem = bus.dm_req && !bus.dm_ack;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a transaction-level reference model
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory (0 none, 1 fetch, 2 data) and the request it issued.
    int          m_owner;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_wstrb;
    int          m_starve;

    always @(posedge clk or posedge reset) begin : model
        bit fg, dg;
        if (reset) begin
            m_owner  <= 0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_we     <= 1'b0;
            m_wstrb  <= '0;
            m_starve <= 0;
        end else begin
            fg = 0;
            dg = 0;
            if (m_owner == 0 && (bus.if_req || bus.dm_req)) begin
                fg = bus.if_req && (!bus.dm_req || m_starve == LIMIT);
                dg = !fg;
            end
            if (m_owner != 0) begin
                if (bus.mem_ready) m_owner <= 0;
            end else if (fg) begin
                m_owner <= 1;
                m_addr  <= bus.if_addr;
                m_we    <= 1'b0;
                m_wstrb <= '0;
            end else if (dg) begin
                m_owner <= 2;
                m_addr  <= bus.dm_addr;
                m_wdata <= bus.dm_wdata;
                m_we    <= bus.dm_we;
                m_wstrb <= bus.dm_we ? bus.dm_wstrb : 4'h0;
            end
            if (!bus.if_req || fg)             m_starve <= 0;
            else if (dg && m_starve < LIMIT)   m_starve <= m_starve + 1;
        end
    end

    always @(negedge clk) begin
        chk("mem_valid", bus.mem_valid, m_owner != 0);
        chk("mem_addr",  bus.mem_addr,  m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("mem_we",    bus.mem_we,    m_we);
        chk("mem_wstrb", bus.mem_wstrb, m_wstrb);
        chk("if_ack",    bus.if_ack,    (m_owner == 1) && bus.mem_ready);
        chk("dm_ack",    bus.dm_ack,    (m_owner == 2) && bus.mem_ready);
        chk("stall_if",  bus.stall_if,  bus.if_req && !((m_owner == 1) && bus.mem_ready));
        chk("stall_mem", bus.stall_mem, bus.dm_req && !((m_owner == 2) && bus.mem_ready));
        chk("if_rdata",  bus.if_rdata,  bus.mem_rdata);
        chk("dm_rdata",  bus.dm_rdata,  bus.mem_rdata);
        chk("starve",    dut.starve_cnt, m_starve);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_wstrb  = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        step();
        bus.dm_req    = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_dm_ack",    bus.dm_ack,    1'b0);
        chk("rst_stall_mem", bus.stall_mem, 1'b1);
        step();
        bus.dm_req = 1'b0;
        reset      = 1'b0;

        // Lone fetch with zero wait states
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0;
        bus.mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("t1_c0_stall_if", bus.stall_if, 1'b1);
        step();
        @(negedge clk);
        chk("t1_c1_valid",    bus.mem_valid, 1'b1);
        chk("t1_c1_addr",     bus.mem_addr,  32'h0);
        chk("t1_c1_if_ack",   bus.if_ack,    1'b1);
        chk("t1_c1_if_rdata", bus.if_rdata,  32'h0050_0093);
        chk("t1_c1_stall_if", bus.stall_if,  1'b0);
        step();
        bus.if_req = 1'b0;
        step();

        // Simultaneous fetch and load
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h10;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h100;
        bus.dm_wdata  = 32'h1111_1111;
        bus.dm_wstrb  = 4'hf;
        bus.mem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("t2_c0_stall_if", bus.stall_if, 1'b1);
        step();
        @(negedge clk);
        chk("t2_c1_addr",     bus.mem_addr,  32'h100);
        chk("t2_c1_dm_ack",   bus.dm_ack,    1'b1);
        chk("t2_c1_wstrb",    bus.mem_wstrb, 4'h0);
        chk("t2_c1_stall_if", bus.stall_if,  1'b1);
        step();
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("t2_c2_stall_if", bus.stall_if,  1'b1);
        chk("t2_c2_valid",    bus.mem_valid, 1'b0);
        step();
        @(negedge clk);
        chk("t2_c3_addr",     bus.mem_addr, 32'h10);
        chk("t2_c3_if_ack",   bus.if_ack,   1'b1);
        chk("t2_c3_stall_if", bus.stall_if, 1'b0);
        step();
        bus.if_req = 1'b0;
        step();

        // Store with three wait states, then a fetch
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b1;
        bus.dm_addr   = 32'h200;
        bus.dm_wdata  = 32'hDEAD_BEEF;
        bus.dm_wstrb  = 4'b0011;
        bus.mem_ready = 1'b0;
        step();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t3_wait_valid", bus.mem_valid, 1'b1);
            chk("t3_wait_addr",  bus.mem_addr,  32'h200);
            chk("t3_wait_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t3_wait_wstrb", bus.mem_wstrb, 4'b0011);
            chk("t3_wait_we",    bus.mem_we,    1'b1);
            chk("t3_wait_ack",   bus.dm_ack,    1'b0);
            chk("t3_wait_stall", bus.stall_mem, 1'b1);
            step();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_ack",   bus.dm_ack,    1'b1);
        chk("t3_ready_stall", bus.stall_mem, 1'b0);
        step();
        bus.dm_req  = 1'b0;
        bus.dm_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        step();
        @(negedge clk);
        chk("t3_fetch_we",    bus.mem_we,    1'b0);
        chk("t3_fetch_wstrb", bus.mem_wstrb, 4'h0);
        chk("t3_fetch_addr",  bus.mem_addr,  32'h44);
        chk("t3_fetch_ack",   bus.if_ack,    1'b1);
        step();
        bus.if_req = 1'b0;
        step();

        // Starvation: both held, data x4, fetch, data
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h40;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h300;
        for (int c = 1; c <= 11; c++) begin
            step();
            @(negedge clk);
            if (c % 2 == 1) begin
                chk("t4_addr",   bus.mem_addr, (c == 9) ? 32'h40 : 32'h300);
                chk("t4_if_ack", bus.if_ack,   c == 9);
                chk("t4_dm_ack", bus.dm_ack,   c != 9);
            end
            if (c == 7) chk("t4_starve_sat",  dut.starve_cnt, 4'd4);
            if (c == 9) chk("t4_starve_zero", dut.starve_cnt, 4'd0);
        end
        step();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        step();

        // Reset in the middle of a data transaction
        bus.dm_req    = 1'b1;
        bus.dm_addr   = 32'h500;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h77;
        step();
        #2;
        chk("t5_pre_valid", bus.mem_valid, 1'b1);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk("t5_rst_valid", bus.mem_valid, 1'b0);
        chk("t5_rst_ack",   bus.dm_ack,    1'b0);
        chk("t5_rst_stall", bus.stall_mem, 1'b1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_idle_valid", bus.mem_valid, 1'b0);
        step();
        @(negedge clk);
        chk("t5_regrant_valid", bus.mem_valid, 1'b1);
        chk("t5_regrant_addr",  bus.mem_addr,  32'h500);
        chk("t5_regrant_ack",   bus.dm_ack,    1'b1);
        chk("t5_regrant_rdata", bus.dm_rdata,  32'h77);
        step();
        bus.dm_req = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
